// File: rtl/led_frame_pkg.sv
// Shared definitions for the LED matrix serial load path.
// The serializer, the matrix driver and the frame-store block all use these.
package led_frame_pkg;

  localparam int NBITS_DEFAULT = 64;
  localparam int HALF_DEFAULT  = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    STRB,
    GAP
  } tx_state_t;

endpackage

// File: rtl/led_frame_phase_tick.sv
// Phase counter that marks the last dclk cycle of each HALF-cycle phase.
// The counter is held at zero while clear is high. It wraps to zero on tick,
// so every phase change starts a fresh count.
module led_frame_phase_tick #(
  parameter int HALF = 2
) (
  input  logic dclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int PW = $clog2(HALF + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);

  logic [PW-1:0] ph;

  assign tick = (ph == PH_LAST);

  // Count dclk cycles within the current phase and restart on every phase boundary.
  always_ff @(posedge dclk) begin
    if (reset || clear || tick) begin
      ph <= '0;
    end else begin
      ph <= ph + PW'(1);
    end
  end

endmodule

// File: rtl/led_frame_serializer.sv
// Host-side transmitter for the LED matrix serial load protocol.
// Accepts one frame per valid/ready handshake and shifts it out MSB first on
// ser_dat/ser_clk. It then pulses ser_strobe so the driver latches its chain.
// Every output is a register, and ser_dat only moves while ser_clk is low.
module led_frame_serializer
  import led_frame_pkg::*;
#(
  parameter int NBITS = NBITS_DEFAULT,
  parameter int HALF  = HALF_DEFAULT
) (
  input  logic             dclk,
  input  logic             reset,
  input  logic [NBITS-1:0] frame_data,
  input  logic             frame_valid,
  output logic             frame_ready,
  output logic             done,
  output logic             ser_dat,
  output logic             ser_clk,
  output logic             ser_strobe
);

  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  tx_state_t        state;
  tx_state_t        state_next;
  logic [NBITS-1:0] shreg;
  logic [NBITS-1:0] shreg_next;
  logic [BW-1:0]    bitcnt;
  logic [BW-1:0]    bitcnt_next;
  logic             ready_next;
  logic             done_next;
  logic             dat_next;
  logic             clk_next;
  logic             strobe_next;
  logic             tick;
  logic             phase_clear;
  logic             accept;

  assign accept      = frame_valid && frame_ready;
  assign phase_clear = (state == IDLE);

  led_frame_phase_tick #(
    .HALF(HALF)
  ) u_phase (
    .dclk (dclk),
    .reset(reset),
    .clear(phase_clear),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge dclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and next values of the shift register, the bit counter and the
  // serial outputs. Outputs hold their value unless a phase ends.
  always_comb begin
    state_next  = state;
    shreg_next  = shreg;
    bitcnt_next = bitcnt;
    ready_next  = frame_ready;
    done_next   = 1'b0;
    dat_next    = ser_dat;
    clk_next    = ser_clk;
    strobe_next = ser_strobe;

    case (state)
      IDLE: begin
        if (accept) begin
          shreg_next  = frame_data;
          dat_next    = frame_data[NBITS-1];
          bitcnt_next = '0;
          ready_next  = 1'b0;
          state_next  = LOW;
        end
      end

      LOW: begin
        if (tick) begin
          clk_next   = 1'b1;
          state_next = HIGH;
        end
      end

      HIGH: begin
        if (tick) begin
          clk_next = 1'b0;
          if (bitcnt == LAST_BIT) begin
            dat_next    = 1'b0;
            strobe_next = 1'b1;
            state_next  = STRB;
          end else begin
            // Rotating instead of shifting keeps every shreg bit in use. The
            // bit that wraps into the bottom position is never transmitted.
            shreg_next  = {shreg[NBITS-2:0], shreg[NBITS-1]};
            dat_next    = shreg[NBITS-2];
            bitcnt_next = bitcnt + BW'(1);
            state_next  = LOW;
          end
        end
      end

      STRB: begin
        if (tick) begin
          strobe_next = 1'b0;
          state_next  = GAP;
        end
      end

      GAP: begin
        if (tick) begin
          done_next  = 1'b1;
          ready_next = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and output registers. Reset drops any frame in flight.
  always_ff @(posedge dclk) begin
    if (reset) begin
      shreg       <= '0;
      bitcnt      <= '0;
      frame_ready <= 1'b1;
      done        <= 1'b0;
      ser_dat     <= 1'b0;
      ser_clk     <= 1'b0;
      ser_strobe  <= 1'b0;
    end else begin
      shreg       <= shreg_next;
      bitcnt      <= bitcnt_next;
      frame_ready <= ready_next;
      done        <= done_next;
      ser_dat     <= dat_next;
      ser_clk     <= clk_next;
      ser_strobe  <= strobe_next;
    end
  end

endmodule

// File: tb/tb_led_frame_serializer.sv
// Scoreboard bench for led_frame_serializer.
// It uses a 64-bit/HALF=2 instance and an 8-bit/HALF=1 instance, each feeding
// a behavioural driver shift chain and display buffer.
module tb_led_frame_serializer;

  logic        dclk  = 1'b0;
  logic        reset = 1'b1;

  logic [63:0] data_a  = '0;
  logic        valid_a = 1'b0;
  logic        ready_a, done_a, ser_dat_a, ser_clk_a, ser_strobe_a;

  logic [7:0]  data_b  = '0;
  logic        valid_b = 1'b0;
  logic        ready_b, done_b, ser_dat_b, ser_clk_b, ser_strobe_b;

  always #5 dclk = ~dclk;

  led_frame_serializer #(.NBITS(64), .HALF(2)) dut_a (
    .dclk(dclk), .reset(reset), .frame_data(data_a), .frame_valid(valid_a),
    .frame_ready(ready_a), .done(done_a), .ser_dat(ser_dat_a),
    .ser_clk(ser_clk_a), .ser_strobe(ser_strobe_a)
  );

  led_frame_serializer #(.NBITS(8), .HALF(1)) dut_b (
    .dclk(dclk), .reset(reset), .frame_data(data_b), .frame_valid(valid_b),
    .frame_ready(ready_b), .done(done_b), .ser_dat(ser_dat_b),
    .ser_clk(ser_clk_b), .ser_strobe(ser_strobe_b)
  );

  // Behavioural matrix driver: shift on data clock rise, latch on strobe rise.
  logic [63:0] chain_a = '0;
  logic [63:0] vbuf_a  = '0;
  logic [7:0]  chain_b = '0;
  logic [7:0]  vbuf_b  = '0;

  always @(posedge ser_clk_a)    chain_a <= {chain_a[62:0], ser_dat_a};
  always @(posedge ser_strobe_a) vbuf_a  <= chain_a;
  always @(posedge ser_clk_b)    chain_b <= {chain_b[6:0], ser_dat_b};
  always @(posedge ser_strobe_b) vbuf_b  <= chain_b;

  typedef struct {
    string       name;
    int          dut;
    logic [63:0] frame;
    int          first_rise;
    int          last_rise;
    int          strobe_rel;
    int          done_rel;
    int          rises;
    int          ones;
  } exp_t;

  typedef struct {
    string       name;
    int          at;
    int          dut;
    logic [4:0]  outs;
    bit          chk_vbuf;
    logic [63:0] vbuf;
    int          strobes;
  } snap_t;

  exp_t  sb[$];
  snap_t snaps[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit end_req = 1'b0;
  bit end_ack = 1'b0;

  always @(posedge dclk) cyc <= cyc + 1;

  // {frame_ready, done, ser_clk, ser_dat, ser_strobe}
  function automatic logic [4:0] outs_of(int d);
    if (d == 0) return {ready_a, done_a, ser_clk_a, ser_dat_a, ser_strobe_a};
    return {ready_b, done_b, ser_clk_b, ser_dat_b, ser_strobe_b};
  endfunction

  function automatic logic [63:0] vbuf_of(int d);
    if (d == 0) return vbuf_a;
    return {56'b0, vbuf_b};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor state per instance
  bit   active[2];
  int   acc_edge[2];
  int   rises[2];
  int   ones[2];
  int   first_r[2];
  int   last_r[2];
  int   strb_rel[2];
  int   viol[2];
  int   strobe_total[2];
  logic p_clk[2];
  logic p_dat[2];
  logic p_strb[2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      active[d] = 1'b0; acc_edge[d] = 0; rises[d] = 0; ones[d] = 0;
      first_r[d] = -1; last_r[d] = -1; strb_rel[d] = -1; viol[d] = 0;
      strobe_total[d] = 0; p_clk[d] = 1'b0; p_dat[d] = 1'b0; p_strb[d] = 1'b0;
    end
  end

  // Monitor: compares snapshots and completed frames against the scoreboard.
  always @(negedge dclk) begin
    snap_t      s;
    exp_t       e;
    logic [4:0] o;
    logic       vld;
    int         rel;

    while (snaps.size() > 0 && snaps[0].at <= cyc) begin
      s = snaps.pop_front();
      chk({s.name, " outs"}, 64'(outs_of(s.dut)), 64'(s.outs));
      if (s.chk_vbuf) chk({s.name, " vbuf"}, vbuf_of(s.dut), s.vbuf);
      if (s.strobes >= 0) chk({s.name, " strobes"}, 64'(strobe_total[s.dut]), 64'(s.strobes));
    end

    for (int d = 0; d < 2; d++) begin
      o   = outs_of(d);
      vld = (d == 0) ? valid_a : valid_b;
      if (reset) begin
        active[d] = 1'b0;
      end else begin
        if (o[0] && !p_strb[d]) strobe_total[d]++;
        if (active[d]) begin
          rel = cyc - acc_edge[d];
          if (o[2] && !p_clk[d]) begin
            rises[d]++;
            if (o[1]) ones[d]++;
            if (rises[d] == 1) first_r[d] = rel;
            last_r[d] = rel;
          end
          if ((p_clk[d] && o[2] && (o[1] != p_dat[d])) || (o[2] && o[0])) viol[d]++;
          if (o[0] && !p_strb[d]) strb_rel[d] = rel;
        end
        if (o[3]) begin
          if (!active[d] || sb.size() == 0) begin
            chk($sformatf("spurious done dut%0d", d), 64'(o[3]), 64'(0));
          end else begin
            e = sb.pop_front();
            chk({e.name, " dut"},        64'(d),                   64'(e.dut));
            chk({e.name, " vbuf"},       vbuf_of(d),               e.frame);
            chk({e.name, " first rise"}, 64'(first_r[d]),          64'(e.first_rise));
            chk({e.name, " last rise"},  64'(last_r[d]),           64'(e.last_rise));
            chk({e.name, " strobe"},     64'(strb_rel[d]),         64'(e.strobe_rel));
            chk({e.name, " done"},       64'(cyc - acc_edge[d]),   64'(e.done_rel));
            chk({e.name, " rises"},      64'(rises[d]),            64'(e.rises));
            chk({e.name, " ones"},       64'(ones[d]),             64'(e.ones));
            chk({e.name, " hazards"},    64'(viol[d]),             64'(0));
            active[d] = 1'b0;
          end
        end
        if (vld && o[4]) begin
          active[d] = 1'b1; acc_edge[d] = cyc + 1; rises[d] = 0; ones[d] = 0;
          first_r[d] = -1; last_r[d] = -1; strb_rel[d] = -1; viol[d] = 0;
        end
      end
      p_clk[d]  = o[2];
      p_dat[d]  = o[1];
      p_strb[d] = o[0];
    end

    if (end_req && !end_ack) begin
      chk("scoreboard drained", 64'(sb.size()),    64'(0));
      chk("snapshots drained",  64'(snaps.size()), 64'(0));
      end_ack = 1'b1;
    end
  end

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic push_snap(string name, int d, logic [4:0] outs, bit cv,
                           logic [63:0] vb, int strobes);
    snap_t s;
    s.name = name; s.at = cyc; s.dut = d; s.outs = outs;
    s.chk_vbuf = cv; s.vbuf = vb; s.strobes = strobes;
    snaps.push_back(s);
  endtask

  task automatic push_exp(string name, int d, logic [63:0] f, int first_rise,
                          int last_rise, int strobe_rel, int done_rel, int nrises);
    exp_t e;
    e.name = name; e.dut = d; e.frame = f; e.first_rise = first_rise;
    e.last_rise = last_rise; e.strobe_rel = strobe_rel; e.done_rel = done_rel;
    e.rises = nrises; e.ones = $countones(f);
    sb.push_back(e);
  endtask

  task automatic wait_accept(int d);
    logic [4:0] o;
    bit         ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      o = outs_of(d);
      if (!o[4]) ok = 1'b1;
    end
    if (!ok) push_snap("accept timeout", d, 5'b00000, 1'b0, '0, -1);
  endtask

  task automatic wait_done(int d);
    logic [4:0] o;
    bit         ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      o = outs_of(d);
      if (o[3]) ok = 1'b1;
    end
    if (!ok) push_snap("done timeout", d, 5'b11000, 1'b0, '0, -1);
  endtask

  // Default instance: rises at 2..254, strobe 256, done 260. Small: 1..15, 16, 18.
  task automatic applyStimulus(int d, string name, logic [63:0] f);
    if (d == 0) begin
      data_a = f; valid_a = 1'b1;
      push_exp(name, 0, f, 2, 254, 256, 260, 64);
    end else begin
      data_b = f[7:0]; valid_b = 1'b1;
      push_exp(name, 1, f, 1, 15, 16, 18, 8);
    end
    wait_accept(d);
    valid_a = 1'b0; valid_b = 1'b0;
    wait_done(d);
    push_snap({name, " done pulse"}, d, 5'b11000, 1'b0, '0, -1);
    tick();
    push_snap({name, " back idle"}, d, 5'b10000, 1'b0, '0, -1);
  endtask

  logic [63:0] f1 = 64'h0F1E_2D3C_4B5A_6978;
  logic [63:0] f2 = 64'hC3A5_5A3C_9669_F00F;
  logic [63:0] rf = 64'h1234_5678_9ABC_DEF0;
  int          e0;
  bit          fin;

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    push_snap("reset a", 0, 5'b10000, 1'b0, '0, -1);
    push_snap("reset b", 1, 5'b10000, 1'b0, '0, -1);
    tick();
    reset = 1'b0;
    tick();

    applyStimulus(0, "deadbeef", 64'hDEAD_BEEF_0123_4567);
    applyStimulus(0, "msb_lsb",  64'h8000_0000_0000_0001);

    // Back-to-back with frame_valid held; busy-time data changes are ignored.
    data_a = f1; valid_a = 1'b1;
    push_exp("b2b f1", 0, f1, 2, 254, 256, 260, 64);
    push_exp("b2b f2", 0, f2, 2, 254, 256, 260, 64);
    wait_accept(0);
    data_a = '1;
    wait_done(0);
    data_a = f2;
    push_snap("b2b done cycle", 0, 5'b11000, 1'b0, '0, -1);
    tick();
    push_snap("b2b second accepted", 0, {1'b0, 1'b0, 1'b0, f2[63], 1'b0}, 1'b0, '0, -1);
    data_a = '0;
    repeat (40) tick();
    valid_a = 1'b0;
    wait_done(0);
    tick();

    // Reset at edge 100 of a frame: bit 24 is on the wire with ser_clk high.
    data_a = rf; valid_a = 1'b1;
    wait_accept(0);
    valid_a = 1'b0;
    e0 = cyc;
    while (cyc < e0 + 99) tick();
    push_snap("pre-reset mid-frame", 0, {1'b0, 1'b0, 1'b1, rf[39], 1'b0}, 1'b0, '0, -1);
    reset = 1'b1;
    tick();
    push_snap("reset mid-frame", 0, 5'b10000, 1'b1, f2, 4);
    reset = 1'b0;
    repeat (300) tick();
    push_snap("post-reset hold", 0, 5'b10000, 1'b1, f2, 4);
    tick();

    applyStimulus(1, "small a5", 64'h0000_0000_0000_00A5);

    repeat (2) tick();
    end_req = 1'b1;
    fin = 1'b0;
    for (int i = 0; i < 10 && !fin; i++) begin
      tick();
      if (end_ack) fin = 1'b1;
    end
    if (!fin) begin
      $display("[TB] FAIL monitor handshake: got no ack expected ack");
      $fatal(1, "[TB] monitor stalled");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
